// File: rtl/key_schedule_inv_pkg.sv
// Shared constants, state encoding and forward S-box for the PRESENT-80
// inverse key-schedule slice.
package key_schedule_inv_pkg;

    localparam int KEY_W  = 80;
    localparam int RK_W   = 64;
    localparam int ROUNDS = 31;
    localparam int ROT_L  = 61;
    localparam int ROT_R  = 19;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/key_schedule.sv
// One forward PRESENT-80 key-schedule round: rotate left 61, S-box the top
// nibble, fold the round counter into bits 19:15.
module key_schedule
    import key_schedule_inv_pkg::*;
(
    input  logic [KEY_W-1:0] key,
    input  logic [4:0]       rc,
    output logic [KEY_W-1:0] next_key
);

    logic [KEY_W-1:0] t;

    always_comb begin
        t        = {key[ROT_R-1:0], key[KEY_W-1:ROT_R]};
        t[79:76] = sbox_fwd(t[79:76]);
        t[19:15] = t[19:15] ^ rc;
        next_key = t;
    end

endmodule

// File: rtl/sbox_inv.sv
// 4-bit PRESENT inverse S-box.
module sbox_inv (
    input  logic [3:0] x,
    output logic [3:0] y
);

    always_comb begin
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
    end

endmodule

// File: rtl/key_schedule_inv.sv
// Runs the PRESENT-80 schedule forward to K32, then streams round keys back
// down to K1 over a valid/ready port, undoing one round per accepted key.
module key_schedule_inv
    import key_schedule_inv_pkg::*;
#(
    parameter int KEY_W = 80,
    parameter int RK_W  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [RK_W-1:0]  rk_out,
    output logic [5:0]       rk_idx,
    output logic             done
);

    state_t           state;
    logic [KEY_W-1:0] k;
    logic [5:0]       idx;
    logic             done_r;

    logic [KEY_W-1:0] k_fwd;
    logic [KEY_W-1:0] u_x;
    logic [KEY_W-1:0] k_inv;
    logic [4:0]       rc_inv;
    logic [3:0]       sinv_y;

    key_schedule u_fwd (
        .key      (k),
        .rc       (idx[4:0]),
        .next_key (k_fwd)
    );

    // Undo round idx-1: strip its counter, invert the S-box, rotate right 61.
    assign rc_inv = idx[4:0] - 5'd1;
    assign u_x    = {k[79:20], k[19:15] ^ rc_inv, k[14:0]};

    sbox_inv u_sinv (
        .x (u_x[79:76]),
        .y (sinv_y)
    );

    assign k_inv = {u_x[60:0], sinv_y, u_x[75:61]};

    // Valid/ready: a key is transferred on a rising edge where rk_valid and
    // rk_ready are both high; rk_out/rk_idx stay stable until that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            k      <= '0;
            idx    <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        k     <= key_in;
                        idx   <= 6'd1;
                        state <= ST_FWD;
                    end
                end
                ST_FWD: begin
                    k   <= k_fwd;
                    idx <= idx + 6'd1;
                    if (idx == 6'(ROUNDS)) begin
                        state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (rk_ready) begin
                        if (idx == 6'd1) begin
                            done_r <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            k   <= k_inv;
                            idx <= idx - 6'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state != ST_IDLE);
    assign rk_valid = (state == ST_EMIT);
    assign rk_out   = k[KEY_W-1 -: RK_W];
    assign rk_idx   = idx;
    assign done     = done_r;

endmodule

// File: tb/tb_key_schedule_inv.sv
// Directed bench for key_schedule_inv: forward-schedule reference model,
// expected-key queue, stalls, ignored loads and mid-run resets.
module tb_key_schedule_inv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [79:0] key_in;
    logic        busy;
    logic        rk_valid;
    logic        rk_ready;
    logic [63:0] rk_out;
    logic [5:0]  rk_idx;
    logic        done;

    logic [3:0]  sbi_in;
    logic [3:0]  sbi_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] exp_q[$];
    logic [5:0]  expi_q[$];
    logic [63:0] last_rk2;
    logic [63:0] last_rk1;

    key_schedule_inv #(.KEY_W(80), .RK_W(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .done     (done)
    );

    sbox_inv u_sbi (
        .x (sbi_in),
        .y (sbi_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_sbox(input logic [3:0] x);
        logic [3:0] tbl [16];
        tbl = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        return tbl[x];
    endfunction

    function automatic logic [79:0] ref_round(input logic [79:0] kk, input logic [4:0] rc);
        logic [79:0] t;
        t        = {kk[18:0], kk[79:19]};
        t[79:76] = ref_sbox(t[79:76]);
        t[19:15] = t[19:15] ^ rc;
        return t;
    endfunction

    // Loads key, then drains all 32 round keys with rk_ready random at the
    // given stall percentage; poke=1 also pulses load during FWD, EMIT and
    // on the final handshake.
    task automatic run_seq(input logic [79:0] key, input int stall_pct, input bit poke);
        logic [79:0] ks [1:32];
        logic [63:0] held_rk;
        logic [5:0]  held_idx;
        logic [5:0]  cur_i;
        bit          held_v;
        bit          finished;
        int          cyc;
        int          first;
        int          dones;

        ks[1] = key;
        for (int i = 1; i < 32; i++) ks[i+1] = ref_round(ks[i], 5'(i));
        exp_q.delete();
        expi_q.delete();
        for (int i = 32; i >= 1; i--) begin
            exp_q.push_back(ks[i][79:16]);
            expi_q.push_back(6'(i));
        end

        @(negedge clk);
        key_in   = key;
        load     = 1'b1;
        rk_ready = 1'b0;
        @(negedge clk);
        load     = 1'b0;
        cyc      = 1;
        first    = -1;
        dones    = 0;
        held_v   = 1'b0;
        finished = 1'b0;
        held_rk  = '0;
        held_idx = '0;

        while (!finished && cyc < 400) begin
            if (done) dones++;
            if (cyc < 32) check_eq("valid_during_fwd", rk_valid, 0);
            if (rk_valid) begin
                if (first < 0) first = cyc;
                if (held_v) begin
                    check_eq("stall_hold_rk", rk_out, held_rk);
                    check_eq("stall_hold_idx", rk_idx, held_idx);
                end
                if (exp_q.size() > 0) begin
                    check_eq("rk_out", rk_out, exp_q[0]);
                    check_eq("rk_idx", rk_idx, expi_q[0]);
                end else begin
                    check_eq("extra_key", 1, 0);
                end
            end
            rk_ready = ($urandom_range(99) >= stall_pct);
            load = poke && busy && (cyc == 5 || (rk_valid && (cyc == 40 ||
                   (exp_q.size() == 1 && rk_ready))));
            if (rk_valid && rk_ready && exp_q.size() > 0) begin
                cur_i = expi_q.pop_front();
                void'(exp_q.pop_front());
                if (cur_i == 6'd2) last_rk2 = rk_out;
                if (cur_i == 6'd1) begin
                    last_rk1 = rk_out;
                    finished = 1'b1;
                end
                held_v = 1'b0;
            end else if (rk_valid) begin
                held_v   = 1'b1;
                held_rk  = rk_out;
                held_idx = rk_idx;
            end
            @(negedge clk);
            cyc++;
        end

        load     = 1'b0;
        rk_ready = 1'b0;
        check_eq("finished_in_budget", finished, 1);
        check_eq("latency_cycle", 80'(first), 80'(32));
        check_eq("keys_left", 80'(exp_q.size()), 0);
        check_eq("done_early", 80'(dones), 0);
        check_eq("done_pulse", done, 1);
        check_eq("valid_after_last", rk_valid, 0);
        check_eq("busy_after_last", busy, 0);
        @(negedge clk);
        check_eq("done_one_cycle", done, 0);
        check_eq("load_ignored_last", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_valid"}, rk_valid, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_rk_out"}, rk_out, 0);
        check_eq({tag, "_rk_idx"}, rk_idx, 0);
    endtask

    task automatic run_reset(input logic [79:0] key);
        int cyc;
        @(negedge clk);
        key_in   = key;
        load     = 1'b1;
        rk_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cyc  = 1;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("fwd_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_fwd");
        @(negedge clk);
        rst_n = 1'b1;

        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cyc  = 0;
        while (!(rk_valid && rk_idx == 6'd17) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        rk_ready = 1'b0;
        check_eq("reach_idx17", (rk_valid && rk_idx == 6'd17), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_emit");
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(key, 0, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        load     = 1'b0;
        rk_ready = 1'b0;
        key_in   = '0;
        sbi_in   = '0;
        last_rk1 = '0;
        last_rk2 = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int x = 0; x < 16; x++) begin
            sbi_in = ref_sbox(4'(x));
            #1 check_eq("sbox_inv_roundtrip", sbi_out, 80'(x));
        end

        run_seq(80'h0, 0, 1'b0);
        check_eq("zero_key_rk2", last_rk2, 64'hC000000000000000);
        check_eq("zero_key_rk1", last_rk1, 64'h0000000000000000);

        run_seq({80{1'b1}}, 0, 1'b0);
        check_eq("ones_key_rk1", last_rk1, 64'hFFFFFFFFFFFFFFFF);

        run_seq(80'h0123456789ABCDEF0123, 40, 1'b0);
        run_seq(80'hFEDCBA98765432100F1E, 70, 1'b0);
        run_seq(80'h5A5AA5A5C3C33C3C9696, 30, 1'b1);
        run_reset(80'h13579BDF02468ACE1111);

        for (int n = 0; n < 1000; n++) begin
            run_seq({$urandom(), $urandom(), 16'($urandom())}, 0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
